debug_slave_vji_host: RTL and testbench
=======================================

Name: debug_slave_vji_host

Overview:
- Simulation-capable host-side driver for the Nios II debug slave's virtual-JTAG port.
- It is the initiator of the virtual-JTAG scan protocol that the debug slave answers.
- Turns a command (IR value + DR word) into a complete virtual scan: UIR, CDR, DR shift, UDR, RTI. It generates tck, tdi and the virtual-state strobes, and returns the captured tdo word.
- Replaces the tied-off vji_* stimulus in the debug-slave test environment; also usable as an on-chip scan master.

Parameters:
- CLK_DIV, 4, tck half-period in clk cycles (>=1)
- IR_WIDTH, 2, virtual IR width
- DR_WIDTH, 38, debug data-register width (matches jdo/sr)
- RTI_CYCLES, 2, tck periods spent in run-test-idle after UDR (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_ir  in  IR_WIDTH  IR value for this scan
- cmd_dr  in  DR_WIDTH  DR value shifted out on tdi, LSB first
- resp_valid  out  1  captured word available
- resp_ready  in  1  consumer accepts response
- resp_dr  out  DR_WIDTH  word captured from tdo
- vji_tck  out  1  generated test clock
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  IR_WIDTH  virtual IR presented to slave
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state indicators

Behaviour:
- Reset values: cmd_ready=1, resp_valid=0, resp_dr=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, all state indicators 0, FSM=IDLE.
- tck period: tck is low for CLK_DIV clk cycles, then high for CLK_DIV cycles.
  - Rise strobe on the low-to-high transition, fall strobe on high-to-low.
  - tck is held low in IDLE and DONE.
- FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> DONE -> IDLE.
  - UIR, CDR and UDR each last one tck period.
  - SDR lasts DR_WIDTH periods.
  - RTI lasts RTI_CYCLES periods.
  - State changes and tdi updates occur only at a tck period boundary (end of high phase).
- IDLE: cmd_ready = !resp_valid. On cmd_valid&&cmd_ready (cycle T):
  - cmd_dr is loaded into the shift register and cmd_ir into vji_ir_in.
  - FSM enters UIR at T+1 with tck low.
- vji_ir_in is held from UIR until the next accepted command; it is not cleared at DONE.
- Each state indicator is high exactly while the FSM is in its state.
- SDR shift:
  - vji_tdi = shreg[0], valid during the whole tck period.
  - On each tck rise strobe, vji_tdo is shifted into the capture register MSB-first-in (right shift).
  - At each period end, shreg shifts right.
  - After DR_WIDTH rises the capture register holds tdo bit0..bit(DR_WIDTH-1) in order.
- vji_tdi=0 outside SDR.
- DONE lasts one clk cycle: resp_dr <= capture, resp_valid <= 1, FSM -> IDLE.
- Latency: resp_valid rises at T+2+2*CLK_DIV*(3+DR_WIDTH+RTI_CYCLES). Defaults give T+346.
- resp_valid stays high until resp_valid&&resp_ready; resp_dr is stable meanwhile.
- Command/response interlock: no new command is accepted while a response is pending. The same-cycle resp accept and cmd accept are allowed only in the cycle after resp_valid drops (cmd_ready is registered).
- cmd_valid while busy: ignored and cmd_ready=0; cmd_* need not be held after acceptance.
- Reset asserted mid-scan: immediate return to reset values. A partial scan is discarded and no response is produced.
- CLK_DIV=1: tck toggles every clk cycle and all rules above still hold.

Decomposition:
- Shared package debug_vji_pkg:
  - state enum (IDLE, UIR, CDR, SDR, UDR, RTI, DONE)
  - constant DEBUG_DR_WIDTH=38, DEBUG_IR_WIDTH=2
  - IR code constants for the debug slave's instruction set
- Sub-module debug_vji_tck_gen:
  - phase counter producing vji_tck, rise strobe and period-end strobe
  - enable input; forced low when disabled

Test Plan:
- Loopback (vji_tdo=vji_tdi), cmd_ir=2'b10, cmd_dr=38'h2A_5A5A_A5A5 -> resp_dr=38'h2A_5A5A_A5A5; vji_ir_in=2'b10; exactly 38 tck rises while vji_sdr=1; resp_valid at T+346.
- vji_tdo tied 1, cmd_dr=0 -> resp_dr=38'h3F_FFFF_FFFF; vji_tdi=0 throughout; vji_uir, vji_cdr and vji_udr each high 8 clk, vji_rti high 16 clk.
- Second command on cmd_valid while busy, then resp_ready held low for 50 cycles -> cmd_ready=0 throughout, resp_valid and resp_dr stable; after resp_ready, second command accepted exactly once.
- reset_n dropped during SDR bit 20 -> all outputs at reset values within the same cycle, no resp_valid; a fresh command afterwards returns the correct loopback value.
- CLK_DIV=1, DR_WIDTH=38, tdo=~tdi, cmd_dr=38'h1 -> resp_dr=38'h3F_FFFF_FFFE; tck period 2 clk; resp_valid at T+88.

Source files
------------

// File: rtl/debug_vji_pkg.sv
// Shared types and constants for the host-side virtual-JTAG scan master
// that drives the Nios II debug slave.
package debug_vji_pkg;

    localparam int DEBUG_DR_WIDTH = 38;
    localparam int DEBUG_IR_WIDTH = 2;

    // Debug slave instruction set
    localparam logic [DEBUG_IR_WIDTH-1:0] IR_OCIMEM = 2'b00;
    localparam logic [DEBUG_IR_WIDTH-1:0] IR_TRACE  = 2'b01;
    localparam logic [DEBUG_IR_WIDTH-1:0] IR_BREAK  = 2'b10;
    localparam logic [DEBUG_IR_WIDTH-1:0] IR_DEBUG  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5,
        DONE = 3'd6
    } vji_state_e;

endpackage

// File: rtl/debug_vji_tck_gen.sv
// Test-clock generator: CLK_DIV clk cycles low, CLK_DIV high, with strobes
// marking the upcoming rising edge and the end of each tck period.
module debug_vji_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise,
    output logic o_pend
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HIGH_AT = CW'(CLK_DIV);
    localparam logic [CW-1:0] END_AT  = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Counter parks at zero while disabled so every scan starts with a full low phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (!i_en || r_cnt == END_AT)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tck  = i_en && (r_cnt >= HIGH_AT);
    assign o_rise = i_en && (r_cnt == RISE_AT);
    assign o_pend = i_en && (r_cnt == END_AT);

endmodule

// File: rtl/debug_slave_vji_host.sv
// Virtual-JTAG scan initiator: turns an {IR, DR} command into a
// UIR/CDR/SDR/UDR/RTI sequence and returns the word captured from tdo.
module debug_slave_vji_host
    import debug_vji_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int IR_WIDTH   = DEBUG_IR_WIDTH,
    parameter int DR_WIDTH   = DEBUG_DR_WIDTH,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DR_WIDTH-1:0] resp_dr,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PMAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam logic [PW-1:0] DR_LAST  = PW'(DR_WIDTH - 1);
    localparam logic [PW-1:0] RTI_LAST = PW'(RTI_CYCLES - 1);

    vji_state_e          r_state, w_state_nxt;
    logic [PW-1:0]       r_pcnt;
    logic [DR_WIDTH-1:0] r_shreg, r_cap, r_resp_dr;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_resp_valid, r_cmd_ready;
    logic                w_en, w_rise, w_pend, w_last, w_accept, w_resp_valid_nxt;

    assign w_en     = (r_state != IDLE) && (r_state != DONE);
    assign w_accept = (r_state == IDLE) && cmd_valid && r_cmd_ready;

    debug_vji_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_en    (w_en),
        .o_tck   (vji_tck),
        .o_rise  (w_rise),
        .o_pend  (w_pend)
    );

    // Only SDR and RTI span more than one tck period
    always_comb begin
        w_last = 1'b1;
        case (r_state)
            SDR:     w_last = (r_pcnt == DR_LAST);
            RTI:     w_last = (r_pcnt == RTI_LAST);
            default: w_last = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)          w_state_nxt = UIR;
            UIR:     if (w_pend)            w_state_nxt = CDR;
            CDR:     if (w_pend)            w_state_nxt = SDR;
            SDR:     if (w_pend && w_last)  w_state_nxt = UDR;
            UDR:     if (w_pend)            w_state_nxt = RTI;
            RTI:     if (w_pend && w_last)  w_state_nxt = DONE;
            DONE:                           w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vji_uir = (r_state == UIR);
        vji_cdr = (r_state == CDR);
        vji_sdr = (r_state == SDR);
        vji_udr = (r_state == UDR);
        vji_rti = (r_state == RTI);
        vji_tdi = (r_state == SDR) ? r_shreg[0] : 1'b0;
    end

    assign w_resp_valid_nxt = (r_state == DONE) ? 1'b1 :
                              (r_resp_valid && resp_ready) ? 1'b0 : r_resp_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt       <= '0;
            r_shreg      <= '0;
            r_cap        <= '0;
            r_ir         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_dr    <= '0;
            r_cmd_ready  <= 1'b1;
        end else begin
            if (w_pend)
                r_pcnt <= w_last ? '0 : r_pcnt + 1'b1;
            if (w_accept) begin
                r_shreg <= cmd_dr;
                r_ir    <= cmd_ir;
                r_cap   <= '0;
            end else begin
                if (r_state == SDR && w_pend)
                    r_shreg <= r_shreg >> 1;
                // tdo enters at the MSB so the first captured bit ends up in bit 0
                if (r_state == SDR && w_rise)
                    r_cap <= {vji_tdo, r_cap[DR_WIDTH-1:1]};
            end
            if (r_state == DONE)
                r_resp_dr <= r_cap;
            r_resp_valid <= w_resp_valid_nxt;
            r_cmd_ready  <= (w_state_nxt == IDLE) && !w_resp_valid_nxt;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign resp_valid = r_resp_valid;
    assign resp_dr    = r_resp_dr;
    assign vji_ir_in  = r_ir;

endmodule

// File: tb/tb_debug_slave_vji_host.sv
// Self-checking bench for debug_slave_vji_host: directed/random vector table,
// interlock, mid-scan reset and a CLK_DIV=1 instance.
module tb_debug_slave_vji_host;
    import debug_vji_pkg::*;

    localparam int DW = 38;

    typedef struct {
        logic [1:0]    ir;
        logic [DW-1:0] dr;
        int            mode;   // 1: tdo = word[k]; 0: tdo = tdi ^ word[k]
        logic [DW-1:0] word;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic          cmd_valid0, cmd_ready0, resp_valid0, resp_ready0;
    logic [1:0]    cmd_ir0, ir_in0;
    logic [DW-1:0] cmd_dr0, resp_dr0;
    logic          tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;

    logic          cmd_valid1, cmd_ready1, resp_valid1, resp_ready1;
    logic [1:0]    cmd_ir1, ir_in1;
    logic [DW-1:0] cmd_dr1, resp_dr1;
    logic          tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;

    debug_slave_vji_host #(.CLK_DIV(4), .IR_WIDTH(2), .DR_WIDTH(DW), .RTI_CYCLES(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_ir(cmd_ir0), .cmd_dr(cmd_dr0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_dr(resp_dr0),
        .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0), .vji_ir_in(ir_in0),
        .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0)
    );

    debug_slave_vji_host #(.CLK_DIV(1), .IR_WIDTH(2), .DR_WIDTH(DW), .RTI_CYCLES(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_dr(resp_dr1),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1), .vji_ir_in(ir_in1),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
    );

    int n_run = 0, n_fail = 0;
    int cyc = 0, acc0 = 0;
    int rise0 = 0, rise1 = 0, base0 = 0;
    int c_uir = 0, c_cdr = 0, c_udr = 0, c_rti = 0, c_sdr = 0, c_tdi_out = 0, c_sdr1 = 0;
    int tdo_mode = 0, tdo_k;
    logic [DW-1:0] tdo_word = '0;

    // Slave model: bit k of the scan answers with word[k] or tdi^word[k]
    assign tdo_k = rise0 - base0;
    always_comb begin
        tdo0 = 1'b0;
        if (tdo_k >= 0 && tdo_k < DW)
            tdo0 = (tdo_mode == 1) ? tdo_word[tdo_k] : (tdi0 ^ tdo_word[tdo_k]);
    end
    assign tdo1 = ~tdi1;

    always @(posedge clk) begin
        cyc++;
        if (cmd_valid0 && cmd_ready0) acc0++;
    end
    always @(posedge tck0) if (sdr0) rise0++;
    always @(posedge tck1) if (sdr1) rise1++;
    always @(negedge clk) begin
        if (uir0) c_uir++;
        if (cdr0) c_cdr++;
        if (udr0) c_udr++;
        if (rti0) c_rti++;
        if (sdr0) c_sdr++;
        if (tdi0 && !sdr0) c_tdi_out++;
        if (sdr1) c_sdr1++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_scan(input int mode, input logic [DW-1:0] dr,
                                               input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int k = 0; k < DW; k++) r[k] = (mode == 1) ? w[k] : (dr[k] ^ w[k]);
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_dr();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        return r64[DW-1:0];
    endfunction

    task automatic wait_resp0(output bit ok);
        int b = 0;
        while (!resp_valid0 && b < 2000) begin @(negedge clk); b++; end
        ok = resp_valid0;
        if (!ok) chk("resp_timeout0", 64'd0, 64'd1);
    endtask

    task automatic run0(input logic [1:0] ir, input logic [DW-1:0] dr, input int mode,
                        input logic [DW-1:0] w, input logic [DW-1:0] exp, input bit full);
        int b, a, s_uir, s_cdr, s_udr, s_rti, s_sdr, s_tdi;
        bit ok;
        @(negedge clk);
        b = 0;
        while (!cmd_ready0 && b < 1000) begin @(negedge clk); b++; end
        chk("cmd_ready_idle", 64'(cmd_ready0), 64'd1);
        tdo_mode = mode; tdo_word = w; base0 = rise0;
        s_uir = c_uir; s_cdr = c_cdr; s_udr = c_udr; s_rti = c_rti; s_sdr = c_sdr; s_tdi = c_tdi_out;
        cmd_valid0 = 1'b1; cmd_ir0 = ir; cmd_dr0 = dr;
        @(posedge clk); #1 a = cyc;
        @(negedge clk);
        cmd_valid0 = 1'b0; cmd_ir0 = ~ir; cmd_dr0 = ~dr;
        chk("cmd_ready_busy", 64'(cmd_ready0), 64'd0);
        wait_resp0(ok);
        if (ok) begin
            chk("resp_dr", 64'(resp_dr0), 64'(exp));
            chk("latency", 64'(cyc - a + 1), 64'd346);
            chk("ir_in", 64'(ir_in0), 64'(ir));
            if (full) begin
                chk("sdr_rises", 64'(rise0 - base0), 64'd38);
                chk("uir_clks", 64'(c_uir - s_uir), 64'd8);
                chk("cdr_clks", 64'(c_cdr - s_cdr), 64'd8);
                chk("udr_clks", 64'(c_udr - s_udr), 64'd8);
                chk("rti_clks", 64'(c_rti - s_rti), 64'd16);
                chk("sdr_clks", 64'(c_sdr - s_sdr), 64'd304);
                chk("tdi_outside_sdr", 64'(c_tdi_out - s_tdi), 64'd0);
            end
        end
        resp_ready0 = 1'b1;
        @(negedge clk);
        resp_ready0 = 1'b0;
        chk("resp_drop", 64'(resp_valid0), 64'd0);
        chk("ir_in_held", 64'(ir_in0), 64'(ir));
    endtask

    task automatic run1(input logic [DW-1:0] dr);
        int b, a, s_sdr, s_rise;
        @(negedge clk);
        s_sdr = c_sdr1; s_rise = rise1;
        cmd_valid1 = 1'b1; cmd_ir1 = IR_DEBUG; cmd_dr1 = dr;
        @(posedge clk); #1 a = cyc;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        b = 0;
        while (!resp_valid1 && b < 1000) begin @(negedge clk); b++; end
        chk("div1_resp_dr", 64'(resp_dr1), 64'(ref_scan(0, dr, '1)));
        chk("div1_latency", 64'(cyc - a + 1), 64'd88);
        chk("div1_rises", 64'(rise1 - s_rise), 64'd38);
        chk("div1_sdr_clks", 64'(c_sdr1 - s_sdr), 64'd76);
        resp_ready1 = 1'b1;
        @(negedge clk);
        resp_ready1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        logic [DW-1:0] dA, dB, dC;
        int b, bad, a0;
        bit ok;

        vt[0].ir = IR_BREAK;  vt[0].dr = 38'h2A_5A5A_A5A5; vt[0].mode = 0;
        vt[0].word = '0;      vt[0].exp = 38'h2A_5A5A_A5A5;
        vt[1].ir = IR_OCIMEM; vt[1].dr = '0;               vt[1].mode = 1;
        vt[1].word = '1;      vt[1].exp = 38'h3F_FFFF_FFFF;
        for (int i = 2; i < 6; i++) begin
            vt[i].ir   = 2'($urandom_range(0, 3));
            vt[i].dr   = rnd_dr();
            vt[i].mode = int'($urandom_range(0, 1));
            vt[i].word = rnd_dr();
            vt[i].exp  = ref_scan(vt[i].mode, vt[i].dr, vt[i].word);
        end

        reset_n = 1'b0;
        cmd_valid0 = 0; cmd_ir0 = '0; cmd_dr0 = '0; resp_ready0 = 0;
        cmd_valid1 = 0; cmd_ir1 = '0; cmd_dr1 = '0; resp_ready1 = 0;
        #12;
        chk("rst_cmd_ready", 64'(cmd_ready0), 64'd1);
        chk("rst_outs", 64'({tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0, resp_valid0}), 64'd0);
        chk("rst_resp_dr", 64'(resp_dr0), 64'd0);
        chk("rst_ir_in", 64'(ir_in0), 64'd0);
        chk("rst_cmd_ready1", 64'(cmd_ready1), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run0(vt[i].ir, vt[i].dr, vt[i].mode, vt[i].word, vt[i].exp, 1'b1);

        // Command while busy, then a stalled response
        dA = rnd_dr(); dB = rnd_dr();
        @(negedge clk);
        tdo_mode = 0; tdo_word = '0; base0 = rise0;
        cmd_valid0 = 1'b1; cmd_ir0 = IR_TRACE; cmd_dr0 = dA;
        @(posedge clk);
        @(negedge clk);
        cmd_ir0 = IR_DEBUG; cmd_dr0 = dB;
        bad = 0; b = 0;
        while (!resp_valid0 && b < 2000) begin
            if (cmd_ready0) bad++;
            @(negedge clk); b++;
        end
        chk("busy_ready_low", 64'(bad), 64'd0);
        chk("resp_A", 64'(resp_dr0), 64'(dA));
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!resp_valid0 || resp_dr0 !== dA || cmd_ready0) bad++;
        end
        chk("resp_hold", 64'(bad), 64'd0);
        a0 = acc0;
        resp_ready0 = 1'b1;
        @(negedge clk);
        resp_ready0 = 1'b0;
        base0 = rise0;
        chk("ready_after_drop", 64'(cmd_ready0), 64'd1);
        repeat (10) @(negedge clk);
        cmd_valid0 = 1'b0;
        chk("accept_once", 64'(acc0 - a0), 64'd1);
        wait_resp0(ok);
        chk("resp_B", 64'(resp_dr0), 64'(dB));
        chk("ir_B", 64'(ir_in0), 64'(IR_DEBUG));
        resp_ready0 = 1'b1;
        @(negedge clk);
        resp_ready0 = 1'b0;

        // Reset during SDR bit 20
        dC = rnd_dr();
        @(negedge clk);
        tdo_mode = 0; tdo_word = '0; base0 = rise0;
        cmd_valid0 = 1'b1; cmd_ir0 = IR_BREAK; cmd_dr0 = dC;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        b = 0;
        while (!(sdr0 && rise0 - base0 == 20) && b < 1000) begin @(negedge clk); b++; end
        chk("reached_bit20", 64'(sdr0 && rise0 - base0 == 20), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_outs", 64'({tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0, resp_valid0}), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready0), 64'd1);
        chk("midrst_ir_in", 64'(ir_in0), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (resp_valid0 || sdr0) bad++;
        end
        chk("no_resp_after_rst", 64'(bad), 64'd0);
        dC = rnd_dr();
        run0(IR_TRACE, dC, 0, '0, dC, 1'b1);

        run1(38'h1);
        run1(rnd_dr());

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
